regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: we  input  1  write enable from writeback stage (en_RF).
REQ-004 SHALL have port: waddr  input  4  write register address from writeback stage.
REQ-005 SHALL have port: wdata  input  32 signed  write data from writeback stage (data_RF).
REQ-006 SHALL have ports: raddr_a, raddr_b  input  4 each  decode read addresses.
REQ-007 SHALL have ports: use_a, use_b  input  1 each  instruction actually reads that source.
REQ-008 SHALL have ports: issue  input  1  decode requests issue; issue_wr  input  1  instruction writes RF; issue_dest  input  4  its destination.
REQ-009 SHALL have ports: rdata_a, rdata_b  output  32 signed each  registered read data.
REQ-010 SHALL have port: stall  output  1  combinational; issue refused this cycle.
REQ-011 SHALL have port: busy  output  16  scoreboard, bit n = write pending to register n.
REQ-012 SHALL have port: wr_err  output  1  sticky; write seen to a non-busy register.

Function
REQ-013 SHALL hold 16 x 32-bit registers, all writable, no hardwired zero.
REQ-014 SHALL write wdata into register waddr on rising clk when we=1.
REQ-015 SHALL register rdata_a/rdata_b every cycle: value = register[raddr], latency 1 cycle.
REQ-016 SHALL bypass: if we=1 and waddr==raddr_x in the same cycle, rdata_x SHALL capture wdata, not the old array value.
REQ-017 SHALL compute hazard_x = use_x & busy[raddr_x] & ~(we & waddr==raddr_x), for x in {a,b}.
REQ-018 SHALL compute waw = issue_wr & busy[issue_dest] & ~(we & waddr==issue_dest).
REQ-019 SHALL drive stall = issue & (hazard_a | hazard_b | waw); stall=0 whenever issue=0.
REQ-020 SHALL set busy[issue_dest] on rising clk when issue=1, stall=0, issue_wr=1.
REQ-021 SHALL clear busy[waddr] on rising clk when we=1.
REQ-022 SHALL give set priority: if set and clear target the same register in one cycle, busy stays 1.
REQ-023 SHALL set wr_err when we=1 and busy[waddr]=0 (and not set the same cycle); write still performed; wr_err only cleared by reset.
REQ-024 SHALL allow simultaneous set of one register and clear of a different register in one cycle.
REQ-025 SHALL ignore issue_dest when issue_wr=0 (store, NOP); no busy bit changes.
REQ-026 SHALL update rdata_a/rdata_b even when stall=1; decode re-samples after stall drops.

Reset
REQ-027 SHALL, while rst=0, asynchronously force all 16 registers to 0, busy=16'h0000, rdata_a=rdata_b=0, wr_err=0.
REQ-028 SHALL, on rst=0 mid-operation, drop all pending writes; no state change until first rising clk after rst=1.
REQ-029 SHALL keep stall combinational from inputs and busy; after reset stall=0 unless a hazard is raised by new inputs.

Verification
REQ-030 Reset then raddr_a=3 -> rdata_a=0 next cycle, busy=0, wr_err=0, stall=0.
REQ-031 we=1 waddr=5 wdata=32'hDEADBEEF with raddr_b=5 same cycle -> rdata_b=32'hDEADBEEF next cycle (bypass).
REQ-032 Issue issue_wr=1 issue_dest=7 -> busy=16'h0080; next cycle issue use_a=1 raddr_a=7 -> stall=1; we=1 waddr=7 in that cycle -> stall=0, busy=0 after edge.
REQ-033 busy[2]=1, same cycle we waddr=2 and issue issue_dest=2 -> stall=0, busy[2]=1 after edge (set wins).
REQ-034 we=1 waddr=9 with busy=0 -> register 9 written, wr_err=1 and stays 1 until rst=0.
REQ-035 busy=16'h0010, assert rst=0 between edges -> busy=0, rdata_a=0 immediately without a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// 16 x 32-bit register file with registered, write-bypassed reads and a
// per-register pending-write scoreboard that stalls issue on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]        raddr_a,
    input  logic [ADDR_W-1:0]        raddr_b,
    input  logic                     use_a,
    input  logic                     use_b,
    input  logic                     issue,
    input  logic                     issue_wr,
    input  logic [ADDR_W-1:0]        issue_dest,
    output logic signed [DATA_W-1:0] rdata_a,
    output logic signed [DATA_W-1:0] rdata_b,
    output logic                     stall,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     wr_err
);

    localparam int NREGS = 1 << ADDR_W;

    logic signed [DATA_W-1:0] regs_q [NREGS];
    logic signed [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic signed [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic [NREGS-1:0]         busy_q, busy_d;
    logic [NREGS-1:0]         set_mask, clr_mask;
    logic                     wr_err_q, wr_err_d;

    logic hit_a, hit_b, hit_dest;
    logic hazard_a, hazard_b, waw;
    logic stall_c, set_en;

    // A writeback landing this cycle resolves its own hazard, so it masks the busy bit.
    always_comb begin
        hit_a    = we && (waddr == raddr_a);
        hit_b    = we && (waddr == raddr_b);
        hit_dest = we && (waddr == issue_dest);

        hazard_a = use_a && busy_q[raddr_a] && !hit_a;
        hazard_b = use_b && busy_q[raddr_b] && !hit_b;
        waw      = issue_wr && busy_q[issue_dest] && !hit_dest;

        stall_c  = issue && (hazard_a || hazard_b || waw);
        set_en   = issue && !stall_c && issue_wr;

        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[issue_dest] = 1'b1;
        end
        if (we) begin
            clr_mask[waddr] = 1'b1;
        end

        // Set is ORed in after the clear so a same-register collision stays busy.
        busy_d   = (busy_q & ~clr_mask) | set_mask;
        wr_err_d = wr_err_q || (we && !busy_q[waddr] && !(set_en && (issue_dest == waddr)));

        rdata_a_d = hit_a ? wdata : regs_q[raddr_a];
        rdata_b_d = hit_b ? wdata : regs_q[raddr_b];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= '0;
            wr_err_q  <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            busy_q    <= busy_d;
            wr_err_q  <= wr_err_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign stall   = stall_c;
    assign busy    = busy_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + short random bench for regfile_scoreboard; read data is
// scoreboarded through queues, state is checked against a reference model.
module tb_regfile_scoreboard;

    logic               clk;
    logic               rst;
    logic               we;
    logic [3:0]         waddr;
    logic signed [31:0] wdata;
    logic [3:0]         raddr_a, raddr_b;
    logic               use_a, use_b;
    logic               issue, issue_wr;
    logic [3:0]         issue_dest;
    logic signed [31:0] rdata_a, rdata_b;
    logic               stall;
    logic [15:0]        busy;
    logic               wr_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic        m_err;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .use_a      (use_a),
        .use_b      (use_b),
        .issue      (issue),
        .issue_wr   (issue_wr),
        .issue_dest (issue_dest),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .stall      (stall),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
        use_a = 0; use_b = 0; issue = 0; issue_wr = 0; issue_dest = 0;
    endtask

    // Called with inputs already driven just after a rising edge.
    task automatic cycle(input string tag);
        logic hz_a, hz_b, hz_w, e_stall, set_en;
        logic [31:0] ea, eb;
        hz_a    = use_a & m_busy[raddr_a] & ~(we && waddr == raddr_a);
        hz_b    = use_b & m_busy[raddr_b] & ~(we && waddr == raddr_b);
        hz_w    = issue_wr & m_busy[issue_dest] & ~(we && waddr == issue_dest);
        e_stall = issue & (hz_a | hz_b | hz_w);
        set_en  = issue & ~e_stall & issue_wr;
        ea = (we && waddr == raddr_a) ? wdata : m_regs[raddr_a];
        eb = (we && waddr == raddr_b) ? wdata : m_regs[raddr_b];
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, e_stall});
        if (we) begin
            m_err = m_err | (~m_busy[waddr] & ~(set_en && issue_dest == waddr));
            m_busy[waddr] = 1'b0;
            m_regs[waddr] = wdata;
        end
        if (set_en) m_busy[issue_dest] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".rdata_a"}, rdata_a, qa.pop_front());
        chk({tag, ".rdata_b"}, rdata_b, qb.pop_front());
        chk({tag, ".busy"}, {16'b0, busy}, {16'b0, m_busy});
        chk({tag, ".wr_err"}, {31'b0, wr_err}, {31'b0, m_err});
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        #12;
        chk("rst.busy", {16'b0, busy}, 32'h0);
        chk("rst.rdata_a", rdata_a, 32'h0);
        chk("rst.wr_err", {31'b0, wr_err}, 32'h0);
        chk("rst.stall", {31'b0, stall}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Read after reset
        idle(); raddr_a = 3;
        cycle("r030");
        chk("r030.rdata_a0", rdata_a, 32'h0);

        // Make r5 pending, then write it with bypass onto port b
        idle(); issue = 1; issue_wr = 1; issue_dest = 5;
        cycle("iss5");
        idle(); we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr_b = 5;
        cycle("r031");
        chk("r031.bypass", rdata_b, 32'hDEADBEEF);

        // RAW hazard on r7 and its resolution by same-cycle writeback
        idle(); issue = 1; issue_wr = 1; issue_dest = 7;
        cycle("iss7");
        chk("r032.busy80", {16'b0, busy}, 32'h0080);
        idle(); issue = 1; use_a = 1; raddr_a = 7;
        cycle("raw7");
        idle(); issue = 1; use_a = 1; raddr_a = 7; we = 1; waddr = 7; wdata = 32'h0000_1234;
        cycle("raw7wb");
        chk("r032.busy0", {16'b0, busy}, 32'h0);
        chk("r032.rd", rdata_a, 32'h0000_1234);

        // Set wins over clear on r2
        idle(); issue = 1; issue_wr = 1; issue_dest = 2;
        cycle("iss2");
        idle(); issue = 1; issue_wr = 1; issue_dest = 2; we = 1; waddr = 2; wdata = 32'h2222;
        cycle("r033");
        chk("r033.busy2", {16'b0, busy}, 32'h0004);

        // Set r3 while clearing r2
        idle(); issue = 1; issue_wr = 1; issue_dest = 3; we = 1; waddr = 2; wdata = -32'sd5; raddr_b = 2;
        cycle("r024");
        chk("r024.busy", {16'b0, busy}, 32'h0008);

        // Store-like issue leaves busy alone; hazards on b and WAW
        idle(); issue = 1; issue_dest = 4;
        cycle("store");
        idle(); issue = 1; use_b = 1; raddr_b = 3;
        cycle("rawb");
        idle(); issue = 1; raddr_b = 3;
        cycle("nouseb");
        idle(); use_a = 1; raddr_a = 3;
        cycle("noissue");
        idle(); issue = 1; issue_wr = 1; issue_dest = 3;
        cycle("waw3");
        idle(); we = 1; waddr = 3; wdata = 32'h3333; raddr_a = 3;
        cycle("wb3");
        chk("wb3.busy", {16'b0, busy}, 32'h0);
        chk("wb3.err0", {31'b0, wr_err}, 32'h0);

        // Spurious write sets sticky wr_err
        idle(); we = 1; waddr = 9; wdata = 32'h9999_0009;
        cycle("r034");
        chk("r034.err", {31'b0, wr_err}, 32'h1);
        idle(); raddr_a = 9;
        cycle("r034b");
        chk("r034.rd9", rdata_a, 32'h9999_0009);
        chk("r034.sticky", {31'b0, wr_err}, 32'h1);

        // Short random run against the model
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); waddr = 4'($urandom); wdata = $urandom;
            raddr_a = 4'($urandom); raddr_b = 4'($urandom);
            use_a = 1'($urandom); use_b = 1'($urandom);
            issue = 1'($urandom); issue_wr = 1'($urandom); issue_dest = 4'($urandom);
            cycle("rand");
        end

        // Asynchronous reset mid-operation
        idle(); we = 1; waddr = 4; wdata = 32'h4444; raddr_a = 4;
        cycle("pre35a");
        idle(); issue = 1; issue_wr = 1; issue_dest = 4; raddr_a = 4;
        while (m_busy != 16'h0) begin
            idle(); we = 1; waddr = 4'($clog2(m_busy & -m_busy)); wdata = 0;
            cycle("drain");
        end
        idle(); issue = 1; issue_wr = 1; issue_dest = 4; raddr_a = 4;
        cycle("iss4");
        chk("r035.pre", {16'b0, busy}, 32'h0010);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("r035.busy", {16'b0, busy}, 32'h0);
        chk("r035.rdata_a", rdata_a, 32'h0);
        chk("r035.rdata_b", rdata_b, 32'h0);
        chk("r035.err", {31'b0, wr_err}, 32'h0);
        @(posedge clk); #1;
        chk("r035.hold", {16'b0, busy}, 32'h0);
        rst = 1'b1;
        idle(); raddr_a = 9;
        cycle("post35");
        chk("post35.rd9", rdata_a, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
